// File: rtl/seg7_mux_display.sv
// seg7_mux_display: two-digit multiplexed hex display with a tear-free
// display register loaded at frame boundaries via a req/ack handshake.
module seg7_mux_display #(
    parameter logic [15:0] REFRESH_COUNT = 16'd10_000,
    parameter logic [15:0] BLANK_CYCLES  = 16'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_req,
    input  logic [7:0] value,
    input  logic       flag,
    input  logic       blank_lz,
    output logic       load_ack,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_en
);

    logic [15:0] cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic [7:0]  disp_q, disp_d;
    logic        flag_q, flag_d;
    logic        lz_q, lz_d;
    logic        ack_q, ack_d;

    logic        tick;
    logic        capture;
    logic [3:0]  nib;
    logic        blank_win;
    logic        lz_hide;

    assign tick    = (cnt_q == REFRESH_COUNT - 16'd1);
    // Capture only on the digit-1 -> digit-0 transition so a frame never tears.
    assign capture = tick & sel_q & load_req;

    always_comb begin
        cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
        sel_d  = sel_q ^ tick;
        disp_d = disp_q;
        flag_d = flag_q;
        lz_d   = lz_q;
        ack_d  = capture;
        if (capture) begin
            disp_d = value;
            flag_d = flag;
            lz_d   = blank_lz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 16'd0;
            sel_q  <= 1'b0;
            disp_q <= 8'h00;
            flag_q <= 1'b0;
            lz_q   <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            disp_q <= disp_d;
            flag_q <= flag_d;
            lz_q   <= lz_d;
            ack_q  <= ack_d;
        end
    end

    assign nib = sel_q ? disp_q[7:4] : disp_q[3:0];

    always_comb begin
        seg = 7'h00;
        unique case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

    // Dark window at slot start keeps the previous digit from ghosting.
    assign blank_win = (cnt_q < BLANK_CYCLES);
    assign lz_hide   = sel_q & lz_q & (disp_q[7:4] == 4'h0);

    assign digit_en = (blank_win | lz_hide) ? 2'b00 :
                      (sel_q ? 2'b10 : 2'b01);
    assign dp       = ~sel_q & flag_q;
    assign load_ack = ack_q;

endmodule

// File: doc/seg7_mux_display.md
Name: seg7_mux_display

Overview:
- Output-side counterpart of the keypad encoder path: converts the 8-bit ALU result into two multiplexed hex digits on a common-cathode 7-segment pair.
- Holds a tear-free display register updated only at frame boundaries through a req/ack handshake.
- Drives digit strobes with anti-ghosting blanking, optional leading-zero suppression, and shows the zero flag on the low digit's decimal point.

Parameters:
- REFRESH_COUNT, 16'd10_000: clk cycles per digit slot (1 kHz slot rate at 10 MHz); must be >= 2.
- BLANK_CYCLES, 16'd4: cycles at the start of each slot with both digits dark; must be < REFRESH_COUNT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load_req  input  1  request to capture value/flag/blank_lz; held until load_ack
- value  input  8  byte to display (ALU result)
- flag  input  1  zero flag, shown on digit-0 DP
- blank_lz  input  1  suppress high digit when it is 0
- load_ack  output  1  one-cycle pulse: capture done
- seg  output  7  segments a..g, bit0=a, active high
- dp  output  1  decimal point, active high
- digit_en  output  2  one-hot digit strobe, bit0 = low nibble digit, active high

Behaviour:
- Reset is asynchronous on rst_n low, released synchronously to clk.
- Reset values: cnt=0, digit_sel=0, disp_reg=8'h00, flag_reg=0, lz_reg=0, load_ack=0.
- Outputs at reset: seg=7'h3F, dp=0, digit_en=2'b00; digit_en=2'b01 instead if BLANK_CYCLES=0.
- All outputs are functions of registers only; there is no input-to-output combinational path.
- Prescaler: cnt counts 0..REFRESH_COUNT-1 and wraps to 0. tick = (cnt==REFRESH_COUNT-1).
- digit_sel toggles on tick.
- Nibble select: digit_sel=0 shows disp_reg[3:0]; digit_sel=1 shows disp_reg[7:4].
- seg is the hex decode of the selected nibble: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- digit_en is 2'b00 while cnt < BLANK_CYCLES; otherwise 2'b01 (digit_sel=0) or 2'b10 (digit_sel=1).
- Leading-zero suppression: if lz_reg=1 and disp_reg[7:4]==0, digit_en stays 2'b00 for the whole digit_sel=1 slot. seg is still driven.
- dp = flag_reg when digit_sel=0, else 0.
- Frame boundary is tick while digit_sel=1 (the transition back to digit 0).
- Capture: if load_req=1 on the frame-boundary cycle, then on that edge:
  - disp_reg<=value, flag_reg<=flag, lz_reg<=blank_lz;
  - load_ack<=1 for exactly one cycle.
  - The new value is first shown in the digit-0 slot that starts on the same edge.
- load_req asserted at any other time waits; no capture, no ack.
- Worst-case wait is 2*REFRESH_COUNT cycles.
- Requester drops load_req in the cycle after load_ack. If load_req is still high at the next frame boundary, a fresh capture and ack occur; this is legal, not an error.
- value/flag/blank_lz are sampled only at capture; changes between captures have no effect.
- Reset mid-operation aborts any pending request: no ack is issued, and the display returns to 00 with digit 0 selected.
- Wrap: cnt and digit_sel wrap freely; there is no terminal state.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, release. Expect seg=7'h3F, dp=0, digit_en=00, load_ack=0. Use REFRESH_COUNT=8, BLANK_CYCLES=2.
- Strobe timing (same params): after reset, expect digit_en=00 at cnt 0-1 and 01 at cnt 2-7; then 00 for 2 cycles and 10 for 6. Period is 16 cycles.
- Load A5: raise load_req with value=8'hA5, flag=1 mid digit-0 slot.
  - No ack until the digit_sel=1 tick.
  - Then load_ack is high for 1 cycle.
  - Digit 0 shows seg=6D with dp=1; digit 1 shows seg=77 with dp=0.
- Leading zero: load value=8'h07, blank_lz=1. Expect digit_en never 10; digit 0 shows seg=07. Repeat with blank_lz=0: digit 1 shows 3F on strobe 10.
- Held request: keep load_req=1 for 40 cycles, changing value 8'h12 to 8'h34 between boundaries. Expect an ack at each frame boundary (every 16 cycles) and the display tracking the value sampled at each boundary.
- Async reset mid-wait: assert load_req, then pull rst_n low before the boundary. Outputs go to reset values immediately, with no load_ack during or after reset.
